mc_controller: RTL and testbench

- Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decode with an FSM: FETCH, DECODE, EXE, MEM, WB, HALT.
- It drives PC/IR write enables, register-file and memory strobes, and ALU/ext/mux selects for a shared instruction/data memory.
- Memory is accessed through a req/ready handshake.
- It sits between the IR/opcode fields and the datapath muxes at the CPU top.

---
 rtl/mc_controller_if.sv | 21 ++
 rtl/mc_controller.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - request/ready handshake to the shared instruction/data memory
interface mc_controller_if;
    logic mem_req;
    logic iord;
    logic memwrite;
    logic mem_ready;

    modport master (
        output mem_req,
        output iord,
        output memwrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  memwrite,
        output mem_ready
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS sequencing FSM; MC_PERF_CNT_EN adds cycle/instret counters
module mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      func,
    input  logic            zero,
    mc_controller_if.master mem,
    output logic            irwrite,
    output logic            pcwrite,
    output logic [1:0]      pcsrc,
    output logic            regwrite,
    output logic [1:0]      regdst,
    output logic [1:0]      wbsel,
    output logic            alusrc,
    output logic [1:0]      extop,
    output logic [1:0]      aluop,
    output logic [2:0]      state,
    output logic            halted,
    output logic [1:0]      fault
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_ORI  = 3'd2,
        CL_LUI  = 3'd3,
        CL_LW   = 3'd4,
        CL_SW   = 3'd5,
        CL_BEQ  = 3'd6
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_HALT  = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // Counter value at which the current wait cycle is the MEM_TIMEOUT-th one.
    localparam logic [31:0] WAIT_LIMIT = 32'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    class_t      class_q;
    class_t      dec_class;
    logic [1:0]  fault_q;
    logic [31:0] wait_q;

    logic        is_jump;
    logic        is_halt_instr;
    logic        waiting;
    logic        timeout_now;
    logic        illegal;

    logic        mem_req_c;
    logic        iord_c;
    logic        memwrite_c;
    logic        irwrite_c;
    logic        pcwrite_c;
    logic [1:0]  pcsrc_c;
    logic        regwrite_c;
    logic [1:0]  regdst_c;
    logic [1:0]  wbsel_c;
    logic        alusrc_c;
    logic [1:0]  extop_c;
    logic [1:0]  aluop_c;

    assign is_halt_instr = (opcode == OP_RTYPE) && (func == FN_HALT);
    assign is_jump       = (opcode == OP_J) || (opcode == OP_JAL) ||
                           ((opcode == OP_RTYPE) && (func == FN_JR));

    // A memory stall cycle: request outstanding and memory not done yet.
    assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
    assign timeout_now = (MEM_TIMEOUT != 0) && waiting && (wait_q == WAIT_LIMIT);

    // Classify the instruction that goes through EXE; jumps/halt never need a class.
    always_comb begin
        dec_class = CL_NONE;
        case (opcode)
            OP_RTYPE: begin
                if ((func == FN_ADDU) || (func == FN_SUBU) || (func == FN_SLT)) begin
                    dec_class = CL_R;
                end
            end
            OP_ORI:  dec_class = CL_ORI;
            OP_LUI:  dec_class = CL_LUI;
            OP_LW:   dec_class = CL_LW;
            OP_SW:   dec_class = CL_SW;
            OP_BEQ:  dec_class = CL_BEQ;
            default: dec_class = CL_NONE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; mem_ready beats a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_now) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_halt_instr) begin
                    state_d = S_HALT;
                end else if (is_jump) begin
                    state_d = S_FETCH;
                end else if (dec_class != CL_NONE) begin
                    state_d = S_EXE;
                end else begin
                    state_d = S_HALT;
                    illegal = 1'b1;
                end
            end
            S_EXE: begin
                case (class_q)
                    CL_LW, CL_SW: state_d = S_MEM;
                    CL_BEQ:       state_d = S_FETCH;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    state_d = (class_q == CL_SW) ? S_FETCH : S_WB;
                end else if (timeout_now) begin
                    state_d = S_HALT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath controls from state, latched class, and the live mem_ready/zero.
    always_comb begin
        mem_req_c  = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        pcsrc_c    = 2'b00;
        regwrite_c = 1'b0;
        regdst_c   = 2'b00;
        wbsel_c    = 2'b00;
        alusrc_c   = 1'b0;
        extop_c    = 2'b00;
        aluop_c    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_J) begin
                    pcwrite_c = 1'b1;
                    pcsrc_c   = 2'b10;
                end else if (opcode == OP_JAL) begin
                    pcwrite_c  = 1'b1;
                    pcsrc_c    = 2'b10;
                    regwrite_c = 1'b1;
                    regdst_c   = 2'b10;
                    wbsel_c    = 2'b10;
                end else if (is_jump) begin
                    pcwrite_c = 1'b1;
                    pcsrc_c   = 2'b11;
                end
            end
            S_EXE: begin
                case (class_q)
                    CL_R: aluop_c = 2'b10;
                    CL_ORI: begin
                        alusrc_c = 1'b1;
                        aluop_c  = 2'b11;
                    end
                    CL_LUI: begin
                        alusrc_c = 1'b1;
                        extop_c  = 2'b10;
                    end
                    CL_LW, CL_SW: begin
                        alusrc_c = 1'b1;
                        extop_c  = 2'b01;
                    end
                    CL_BEQ: begin
                        aluop_c = 2'b01;
                        if (zero) begin
                            pcwrite_c = 1'b1;
                            pcsrc_c   = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                alusrc_c   = 1'b1;
                extop_c    = 2'b01;
                // The store strobe drops in the cycle a timeout aborts the access.
                memwrite_c = (class_q == CL_SW) && !timeout_now;
            end
            S_WB: begin
                regwrite_c = 1'b1;
                if (class_q == CL_R) begin
                    regdst_c = 2'b01;
                end else if (class_q == CL_LW) begin
                    wbsel_c = 2'b01;
                end
            end
            default: ;
        endcase
    end

    // Class latch, sticky fault code and memory wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            class_q <= CL_NONE;
            fault_q <= 2'b00;
            wait_q  <= 32'd0;
        end else begin
            if (state_q == S_DECODE) begin
                class_q <= dec_class;
            end
            if (illegal) begin
                fault_q <= 2'b01;
            end else if (timeout_now) begin
                fault_q <= 2'b10;
            end
            if (state_d != state_q) begin
                wait_q <= 32'd0;
            end else if (waiting) begin
                wait_q <= wait_q + 32'd1;
            end
        end
    end

`ifdef MC_PERF_CNT_EN
    // Free-running cycle count outside HALT and retired-instruction count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

    // Everything reads zero while reset is held low.
    assign mem.mem_req  = reset & mem_req_c;
    assign mem.iord     = reset & iord_c;
    assign mem.memwrite = reset & memwrite_c;
    assign irwrite      = reset & irwrite_c;
    assign pcwrite      = reset & pcwrite_c;
    assign pcsrc        = reset ? pcsrc_c  : 2'b00;
    assign regwrite     = reset & regwrite_c;
    assign regdst       = reset ? regdst_c : 2'b00;
    assign wbsel        = reset ? wbsel_c  : 2'b00;
    assign alusrc       = reset & alusrc_c;
    assign extop        = reset ? extop_c  : 2'b00;
    assign aluop        = reset ? aluop_c  : 2'b00;
    assign state        = reset ? state_q  : 3'd0;
    assign halted       = reset & (state_q == S_HALT);
    assign fault        = reset ? fault_q  : 2'b00;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller with MEM_TIMEOUT=4
module tb_mc_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] wb;
        logic       as;
        logic [1:0] ext;
        logic [1:0] alu;
        logic       hlt;
        logic [1:0] flt;
    } ctl_t;

    typedef struct {
        string       nm;
        logic        rdy;
        logic        z;
        ctl_t        v;
        logic [22:0] m;
    } exp_t;

    localparam logic [22:0] M_ALL  = 23'h7FFFFF;
    localparam logic [22:0] M_BASE = 23'h7B9007;
    localparam logic [22:0] M_IORD = 23'h040000;
    localparam logic [22:0] M_PCS  = 23'h006000;
    localparam logic [22:0] M_RD   = 23'h000C00;
    localparam logic [22:0] M_WB   = 23'h000300;
    localparam logic [22:0] M_AS   = 23'h000080;
    localparam logic [22:0] M_EXT  = 23'h000060;
    localparam logic [22:0] M_ALU  = 23'h000018;
    localparam logic [22:0] M_SEL  = M_AS | M_EXT | M_ALU;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        zero = 1'b0;
    logic        irwrite, pcwrite, regwrite, alusrc, halted;
    logic [1:0]  pcsrc, regdst, wbsel, extop, aluop, fault;
    logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    mc_controller_if mem ();

    always #5 clock = ~clock;

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .opcode   (opcode),
        .func     (func),
        .zero     (zero),
        .mem      (mem),
        .irwrite  (irwrite),
        .pcwrite  (pcwrite),
        .pcsrc    (pcsrc),
        .regwrite (regwrite),
        .regdst   (regdst),
        .wbsel    (wbsel),
        .alusrc   (alusrc),
        .extop    (extop),
        .aluop    (aluop),
        .state    (state),
        .halted   (halted),
        .fault    (fault)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    function automatic ctl_t c(input logic [2:0] st, input logic [4:0] strb, input logic [1:0] pcs,
                               input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                               input logic as, input logic [1:0] ext, input logic [1:0] alu,
                               input logic hlt, input logic [1:0] flt);
        return {st, strb, pcs, rw, rd, wb, as, ext, alu, hlt, flt};
    endfunction

    task automatic ex(input string nm, input logic rdy, input logic z, input ctl_t v, input logic [22:0] m);
        exp_t x;
        x.nm = nm; x.rdy = rdy; x.z = z; x.v = v; x.m = m;
        sb.push_back(x);
    endtask

    task automatic ex_fetch(input string nm, input int stalls);
        for (int i = 0; i < stalls; i++)
            ex({nm, "_stall"}, 1'b0, 1'b0, c(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_IORD);
        ex(nm, 1'b1, 1'b0, c(0, 5'b10011, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_IORD | M_PCS);
    endtask

    task automatic ex_decode(input string nm);
        ex(nm, 1'b1, 1'b0, c(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE);
    endtask

    task automatic drive(input logic rdy, input logic z, output ctl_t o);
        mem.mem_ready = rdy;
        zero = z;
        #1;
        o = {state, mem.mem_req, mem.iord, mem.memwrite, irwrite, pcwrite, pcsrc, regwrite,
             regdst, wbsel, alusrc, extop, aluop, halted, fault};
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        ctl_t o;
        exp_t x;
        reset = 1'b0;
        ex("reset_outputs", 1'b1, 1'b1, '0, M_ALL);
        ex("reset_outputs", 1'b1, 1'b1, '0, M_ALL);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        ctl_t o;
        exp_t x;
        opcode = 6'b000000; func = 6'b100001;
        ex_fetch("addu_fetch", 0);
        ex_decode("addu_decode");
        ex("addu_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0), M_BASE | M_SEL);
        ex("addu_wb", 1'b1, 1'b0, c(4, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WB);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
    endtask

    task automatic test_load_store();
        ctl_t o;
        exp_t x;
        opcode = 6'b100011; func = 6'd0;
        ex_fetch("lw_fetch", 0);
        ex_decode("lw_decode");
        ex("lw_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0), M_BASE | M_SEL);
        for (int i = 0; i < 3; i++)
            ex("lw_mem_wait", 1'b0, 1'b0, c(3, 5'b11000, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), M_BASE | M_IORD | M_SEL);
        ex("lw_mem_done", 1'b1, 1'b0, c(3, 5'b11000, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), M_BASE | M_IORD | M_SEL);
        ex("lw_wb", 1'b1, 1'b0, c(4, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WB);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        opcode = 6'b101011;
        ex_fetch("sw_fetch", 0);
        ex_decode("sw_decode");
        ex("sw_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0), M_BASE | M_SEL);
        ex("sw_mem", 1'b1, 1'b0, c(3, 5'b11100, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), M_BASE | M_IORD | M_SEL);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
    endtask

    task automatic test_immediate();
        ctl_t o;
        exp_t x;
        opcode = 6'b001101; func = 6'd0;
        ex_fetch("ori_fetch", 0);
        ex_decode("ori_decode");
        ex("ori_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 0), M_BASE | M_SEL);
        ex("ori_wb", 1'b1, 1'b0, c(4, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WB);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        opcode = 6'b001111;
        ex_fetch("lui_fetch", 0);
        ex_decode("lui_decode");
        ex("lui_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0), M_BASE | M_SEL);
        ex("lui_wb", 1'b1, 1'b0, c(4, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WB);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
    endtask

    task automatic test_branch();
        ctl_t o;
        exp_t x;
        opcode = 6'b000100; func = 6'd0;
        ex_fetch("beq_t_fetch", 0);
        ex_decode("beq_t_decode");
        ex("beq_taken_exe", 1'b1, 1'b1, c(2, 5'b00001, 2'b01, 0, 0, 0, 0, 0, 2'b01, 0, 0), M_BASE | M_PCS | M_AS | M_ALU);
        ex_fetch("beq_nt_fetch", 0);
        ex_decode("beq_nt_decode");
        ex("beq_not_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), M_BASE | M_AS | M_ALU);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
    endtask

    task automatic test_jumps();
        ctl_t o;
        exp_t x;
        logic [5:0] ops [3] = '{6'b000010, 6'b000011, 6'b000000};
        ctl_t       dec [3];
        logic [22:0] msk [3];
        dec[0] = c(1, 5'b00001, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        dec[1] = c(1, 5'b00001, 2'b10, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0);
        dec[2] = c(1, 5'b00001, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
        msk[0] = M_BASE | M_PCS;
        msk[1] = M_BASE | M_PCS | M_RD | M_WB;
        msk[2] = M_BASE | M_PCS;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            func   = 6'b001000;
            ex_fetch("jump_fetch", 0);
            ex($sformatf("jump%0d_decode", k), 1'b1, 1'b0, dec[k], msk[k]);
            while (sb.size() > 0) begin
                drive(sb[0].rdy, sb[0].z, o);
                x = sb.pop_front();
                total++;
                if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        ctl_t o;
        exp_t x;
        logic [5:0] fns [3] = '{6'b100001, 6'b100011, 6'b101010};
        for (int k = 0; k < 6; k++) begin
            opcode = 6'b000000;
            func   = fns[k % 3];
            ex_fetch("b2b_fetch", int'($urandom_range(0, 3)));
            ex_decode("b2b_decode");
            ex("b2b_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0), M_BASE | M_SEL);
            ex("b2b_wb", 1'b1, 1'b0, c(4, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0), M_BASE | M_RD | M_WB);
            while (sb.size() > 0) begin
                drive(sb[0].rdy, sb[0].z, o);
                x = sb.pop_front();
                total++;
                if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
                else passed++;
            end
        end
    endtask

    task automatic test_halt_illegal();
        ctl_t o;
        exp_t x;
        opcode = 6'b000000; func = 6'b000000;
        ex_fetch("halt_fetch", 0);
        ex_decode("halt_decode");
        ex("halt_state", 1'b1, 1'b0, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00), M_BASE);
        ex("halt_state", 1'b1, 1'b0, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00), M_BASE);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        pulse_reset();
        opcode = 6'b111111; func = 6'b100001;
        ex_fetch("ill_fetch", 0);
        ex_decode("ill_decode");
        for (int i = 0; i < 4; i++)
            ex("ill_halt", 1'b1, 1'b1, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01), M_BASE);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        reset = 1'b0;
        ex("reset_in_halt", 1'b1, 1'b1, '0, M_ALL);
        ex("reset_in_halt", 1'b1, 1'b1, '0, M_ALL);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        reset = 1'b1;
        ex_fetch("post_reset_fetch", 0);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        ctl_t o;
        exp_t x;
        pulse_reset();
        opcode = 6'b000000; func = 6'b100001;
        for (int i = 0; i < 4; i++)
            ex("to_fetch_wait", 1'b0, 1'b0, c(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_IORD);
        ex("to_fetch_halt", 1'b1, 1'b0, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10), M_BASE);
        ex("to_fetch_halt", 1'b1, 1'b0, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10), M_BASE);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== 32'd4) $display("FAIL perf_cycle_cnt: got %0d want 4", cycle_cnt);
        else passed++;
        total++;
        if (instret_cnt !== 32'd0) $display("FAIL perf_instret_cnt: got %0d want 0", instret_cnt);
        else passed++;
`endif
        pulse_reset();
        opcode = 6'b101011; func = 6'd0;
        ex_fetch("to_ready_wins", 3);
        ex_decode("to_sw_decode");
        ex("to_sw_exe", 1'b1, 1'b0, c(2, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0), M_BASE | M_SEL);
        for (int i = 0; i < 3; i++)
            ex("to_sw_mem_wait", 1'b0, 1'b0, c(3, 5'b11100, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), M_BASE | M_IORD | M_SEL);
        ex("to_sw_mem_expire", 1'b0, 1'b0, c(3, 5'b11000, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), M_BASE | M_IORD);
        ex("to_mem_halt", 1'b1, 1'b0, c(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10), M_BASE);
        while (sb.size() > 0) begin
            drive(sb[0].rdy, sb[0].z, o);
            x = sb.pop_front();
            total++;
            if ((o & x.m) !== (x.v & x.m)) $display("FAIL %s: got %h want %h", x.nm, o, x.v);
            else passed++;
        end
        pulse_reset();
    endtask

    initial begin
        mem.mem_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_rtype();
        test_load_store();
        test_immediate();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_halt_illegal();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
